// File: rtl/lreport_gen.sv
// Local report generator on the 134-bit UM pipeline: forwards user packets with one
// cycle of latency and inserts counter-snapshot beacon frames toward the CNC.
module lreport_gen #(
  parameter logic [7:0]  LMID       = 8'd11,
  parameter int          CNT_NUM    = 8,
  parameter int          PERIOD_BIT = 20,
  parameter logic [47:0] CNC_MAC    = 48'h010203040506,
  parameter logic [15:0] ETH_TYPE   = 16'h88f7,
  parameter logic [7:0]  PASS_DMID  = 8'd1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_data_wr,
  input  logic [133:0]           in_data,
  input  logic                   in_data_valid,
  input  logic                   in_data_valid_wr,
  output logic                   in_ready,
  output logic                   out_data_wr,
  output logic [133:0]           out_data,
  output logic                   out_data_valid,
  output logic                   out_data_valid_wr,
  input  logic [47:0]            precision_time,
  input  logic [47:0]            local_mac,
  input  logic                   report_en,
  input  logic                   report_req,
  input  logic [64*CNT_NUM-1:0]  cnt_in,
  output logic [15:0]            report_seq,
  output logic [15:0]            report_coalesce_cnt
);

  localparam int         WORDS     = 6 + (CNT_NUM + 1) / 2;
  localparam int         PAD_NUM   = 2 * ((CNT_NUM + 1) / 2);
  localparam int         SNAP_W    = 64 * PAD_NUM;
  localparam int         SEL_W     = $clog2(SNAP_W);
  localparam bit         ODD       = (CNT_NUM % 2) == 1;
  localparam logic [5:0] LAST_IDX  = 6'(WORDS - 1);
  localparam logic [15:0] LEN_BYTES = 16'((WORDS - 2) * 16);
  localparam logic [15:0] CNT_W16   = 16'(CNT_NUM);

  localparam logic [1:0] TAG_HEAD = 2'b01;
  localparam logic [1:0] TAG_BODY = 2'b11;
  localparam logic [1:0] TAG_TAIL = 2'b10;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_PASS   = 2'd1;
  localparam logic [1:0] S_REPORT = 2'd2;

  logic [1:0]        state;
  logic [5:0]        idx;
  logic              pending;
  logic [47:0]       ts_rec;
  logic [SNAP_W-1:0] snap;

  logic              trig;
  logic              head_ok;
  logic              start_rpt;
  logic              rpt_done;
  logic [133:0]      rpt_word;
  logic [5:0]        pidx;
  logic [SEL_W-1:0]  sel;
  logic [127:0]      pair;

  assign trig      = (report_en && (precision_time[PERIOD_BIT-1:0] == '0)) || report_req;
  assign head_ok   = in_data_wr && (in_data[133:132] == TAG_HEAD) && in_ready;
  assign start_rpt = (state == S_IDLE) && !head_ok && pending && !in_data_wr;
  assign rpt_done  = (state == S_REPORT) && (idx == LAST_IDX);

  // A trigger landing on the finishing cycle re-arms rather than coalescing.
  always_ff @(posedge clk) begin
    if (rst) begin
      pending             <= 1'b0;
      report_coalesce_cnt <= 16'h0;
    end else if (trig && (!pending || rpt_done)) begin
      pending <= 1'b1;
    end else if (trig) begin
      if (report_coalesce_cnt != 16'hffff)
        report_coalesce_cnt <= report_coalesce_cnt + 16'h1;
    end else if (rpt_done) begin
      pending <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (trig && (!pending || rpt_done))
      ts_rec <= precision_time;
    if (start_rpt)
      snap <= SNAP_W'(cnt_in);
  end

  always_comb begin
    rpt_word = '0;
    pidx     = idx - 6'd6;
    sel      = SEL_W'({pidx, 7'd0});
    pair     = snap[sel +: 128];
    case (idx)
      6'd0: begin
        rpt_word[133:132] = TAG_HEAD;
        rpt_word[95:88]   = LMID;
      end
      6'd1: rpt_word[133:132] = TAG_BODY;
      6'd2: rpt_word = {TAG_BODY, 4'h0, CNC_MAC, local_mac, ETH_TYPE, 16'h000e};
      6'd3: rpt_word = {TAG_BODY, 4'h0, LEN_BYTES, 112'h0};
      6'd4: rpt_word = {TAG_BODY, 4'h0, 16'h0, report_seq, ts_rec, 48'h0};
      6'd5: rpt_word = {TAG_BODY, 4'h0, CNT_W16, 112'h0};
      default: begin
        // Lower-indexed counter of the pair goes in the upper half.
        rpt_word = {TAG_BODY, 4'h0, pair[63:0], pair[127:64]};
        if (idx == LAST_IDX) begin
          rpt_word[133:132] = TAG_TAIL;
          rpt_word[131:128] = ODD ? 4'd8 : 4'd0;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state             <= S_IDLE;
      idx               <= 6'd0;
      in_ready          <= 1'b0;
      out_data_wr       <= 1'b0;
      out_data          <= '0;
      out_data_valid    <= 1'b0;
      out_data_valid_wr <= 1'b0;
      report_seq        <= 16'h0;
    end else begin
      out_data_wr       <= 1'b0;
      out_data          <= '0;
      out_data_valid    <= 1'b0;
      out_data_valid_wr <= 1'b0;
      case (state)
        S_IDLE: begin
          in_ready <= 1'b1;
          if (head_ok) begin
            out_data_wr       <= 1'b1;
            out_data          <= {in_data[133:88], PASS_DMID, in_data[79:0]};
            out_data_valid    <= in_data_valid;
            out_data_valid_wr <= in_data_valid_wr;
            state             <= S_PASS;
          end else if (start_rpt) begin
            in_ready <= 1'b0;
            idx      <= 6'd0;
            state    <= S_REPORT;
          end
        end
        S_PASS: begin
          out_data_wr       <= in_data_wr;
          out_data          <= in_data;
          out_data_valid    <= in_data_valid;
          out_data_valid_wr <= in_data_valid_wr;
          if (in_data_wr && (in_data[133:132] == TAG_TAIL))
            state <= S_IDLE;
        end
        S_REPORT: begin
          out_data_wr <= 1'b1;
          out_data    <= rpt_word;
          idx         <= idx + 6'd1;
          if (rpt_done) begin
            out_data_valid    <= 1'b1;
            out_data_valid_wr <= 1'b1;
            report_seq        <= report_seq + 16'h1;
            in_ready          <= 1'b1;
            state             <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lreport_gen.sv
// Directed bench for lreport_gen: an 8-counter instance with a 16-cycle period and a
// 3-counter instance exercising the odd-count tail word.
module tb_lreport_gen;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_data_wr;
  logic [133:0] in_data;
  logic         in_data_valid;
  logic         in_data_valid_wr;
  logic [47:0]  precision_time;
  logic [47:0]  local_mac;
  logic         en8, req8, en3, req3;
  logic [511:0] cnt8;
  logic [191:0] cnt3;

  logic         rdy8, wr8, v8, vwr8;
  logic [133:0] d8;
  logic [15:0]  seq8, coal8;
  logic         rdy3, wr3, v3, vwr3;
  logic [133:0] d3;
  logic [15:0]  seq3, coal3;

  int vecs = 0;
  int errs = 0;

  logic [136:0] exp_w;
  logic [136:0] got_w;

  localparam logic [133:0] HEAD_IN  = {2'b01, 4'h0, 128'h0011_2233_4455_6677_8899_aabb_ccdd_eeff};
  localparam logic [133:0] HEAD_OUT = {2'b01, 4'h0, 128'h0011_2233_4401_6677_8899_aabb_ccdd_eeff};
  localparam logic [133:0] BODY_W   = {2'b11, 4'h0, 128'hdead_beef_0000_1111_2222_3333_4444_5555};
  localparam logic [133:0] TAIL_W   = {2'b10, 4'h3, 128'h1234_5678_9abc_def0_0fed_cba9_8765_4321};
  localparam logic [47:0]  T_IDLE   = 48'h0000_0000_1231;

  always #5 clk = ~clk;

  lreport_gen #(.CNT_NUM(8), .PERIOD_BIT(4)) u8 (
    .clk(clk), .rst(rst), .in_data_wr(in_data_wr), .in_data(in_data),
    .in_data_valid(in_data_valid), .in_data_valid_wr(in_data_valid_wr), .in_ready(rdy8),
    .out_data_wr(wr8), .out_data(d8), .out_data_valid(v8), .out_data_valid_wr(vwr8),
    .precision_time(precision_time), .local_mac(local_mac), .report_en(en8),
    .report_req(req8), .cnt_in(cnt8), .report_seq(seq8), .report_coalesce_cnt(coal8)
  );

  lreport_gen #(.CNT_NUM(3), .PERIOD_BIT(4)) u3 (
    .clk(clk), .rst(rst), .in_data_wr(in_data_wr), .in_data(in_data),
    .in_data_valid(in_data_valid), .in_data_valid_wr(in_data_valid_wr), .in_ready(rdy3),
    .out_data_wr(wr3), .out_data(d3), .out_data_valid(v3), .out_data_valid_wr(vwr3),
    .precision_time(precision_time), .local_mac(local_mac), .report_en(en3),
    .report_req(req3), .cnt_in(cnt3), .report_seq(seq3), .report_coalesce_cnt(coal3)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic wr, input logic [133:0] w, input logic v);
    in_data_wr       = wr;
    in_data          = w;
    in_data_valid    = v;
    in_data_valid_wr = v;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    vecs++;
    got_w = {wr8, v8, vwr8, d8};
    if (got_w !== '0 || rdy8 !== 1'b0 || seq8 !== 16'h0 || coal8 !== 16'h0) begin
      errs++;
      $display("FAIL reset_outputs: got wr/v/vwr/data=%h rdy=%b seq=%h coal=%h, want all 0",
               got_w, rdy8, seq8, coal8);
    end
    rst = 1'b0;
    vecs++;
    if (rdy8 !== 1'b0 || rdy3 !== 1'b0) begin
      errs++;
      $display("FAIL reset_ready_low: got %b/%b, want 0/0", rdy8, rdy3);
    end
    tick();
    vecs++;
    if (rdy8 !== 1'b1 || rdy3 !== 1'b1) begin
      errs++;
      $display("FAIL reset_ready_rise: got %b/%b, want 1/1", rdy8, rdy3);
    end
  endtask

  task automatic test_pass();
    logic [133:0] win [3];
    logic [136:0] wexp [3];
    win[0] = HEAD_IN;  wexp[0] = {3'b100, HEAD_OUT};
    win[1] = BODY_W;   wexp[1] = {3'b100, BODY_W};
    win[2] = TAIL_W;   wexp[2] = {3'b111, TAIL_W};
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, win[i], i == 2);
      tick();
      vecs++;
      got_w = {wr8, v8, vwr8, d8};
      if (got_w !== wexp[i] || rdy8 !== 1'b1) begin
        errs++;
        $display("FAIL pass_word%0d: got %h rdy=%b, want %h rdy=1", i, got_w, rdy8, wexp[i]);
      end
    end
    drive(1'b0, '0, 1'b0);
    tick();
    vecs++;
    if (wr8 !== 1'b0 || d8 !== '0) begin
      errs++;
      $display("FAIL pass_idle_after: got wr=%b data=%h, want 0", wr8, d8);
    end
  endtask

  task automatic test_periodic();
    for (int i = 0; i < 8; i++)
      cnt8[64*i +: 64] = {32'hc0de_0000 + 32'(i), 32'h0000_1000 + 32'(i)};
    en8 = 1'b1;
    precision_time = 48'h0000_0000_1230;
    tick();
    en8 = 1'b0;
    precision_time = T_IDLE;
    vecs++;
    if (rdy8 !== 1'b1) begin
      errs++;
      $display("FAIL periodic_ready_before: got %b, want 1", rdy8);
    end
    tick();
    cnt8 = '1;
    vecs++;
    if (rdy8 !== 1'b0) begin
      errs++;
      $display("FAIL periodic_ready_fall: got %b, want 0", rdy8);
    end
    for (int i = 0; i < 10; i++) begin
      tick();
      case (i)
        0: exp_w = {3'b100, 2'b01, 4'h0, 32'h0, 8'd11, 88'h0};
        1: exp_w = {3'b100, 2'b11, 4'h0, 128'h0};
        2: exp_w = {3'b100, 2'b11, 4'h0, 48'h010203040506, 48'ha1a2a3a4a5a6, 16'h88f7, 16'h000e};
        3: exp_w = {3'b100, 2'b11, 4'h0, 16'd128, 112'h0};
        4: exp_w = {3'b100, 2'b11, 4'h0, 16'h0, 16'h0, 48'h0000_0000_1230, 48'h0};
        5: exp_w = {3'b100, 2'b11, 4'h0, 16'd8, 112'h0};
        default: exp_w = {(i == 9) ? 3'b111 : 3'b100, (i == 9) ? 2'b10 : 2'b11, 4'h0,
                          32'hc0de_0000 + 32'(2*(i-6)),   32'h0000_1000 + 32'(2*(i-6)),
                          32'hc0de_0000 + 32'(2*(i-6)+1), 32'h0000_1000 + 32'(2*(i-6)+1)};
      endcase
      vecs++;
      got_w = {wr8, v8, vwr8, d8};
      if (got_w !== exp_w) begin
        errs++;
        $display("FAIL periodic_w%0d: got %h, want %h", i, got_w, exp_w);
      end
    end
    vecs++;
    if (seq8 !== 16'd1 || rdy8 !== 1'b1) begin
      errs++;
      $display("FAIL periodic_done: got seq=%0d rdy=%b, want seq=1 rdy=1", seq8, rdy8);
    end
    tick();
    vecs++;
    if (wr8 !== 1'b0) begin
      errs++;
      $display("FAIL periodic_quiet: got wr=%b, want 0", wr8);
    end
  endtask

  task automatic test_odd_count();
    cnt3 = {64'h3, 64'h2, 64'h1};
    req3 = 1'b1;
    tick();
    req3 = 1'b0;
    tick();
    vecs++;
    if (rdy3 !== 1'b0) begin
      errs++;
      $display("FAIL odd_ready_fall: got %b, want 0", rdy3);
    end
    for (int i = 0; i < 8; i++) begin
      tick();
      got_w = {wr3, v3, vwr3, d3};
      case (i)
        3: exp_w = {3'b100, 2'b11, 4'h0, 16'd96, 112'h0};
        5: exp_w = {3'b100, 2'b11, 4'h0, 16'd3, 112'h0};
        6: exp_w = {3'b100, 2'b11, 4'h0, 64'h1, 64'h2};
        7: exp_w = {3'b111, 2'b10, 4'h8, 64'h3, 64'h0};
        default: exp_w = got_w;
      endcase
      if (i == 3 || i >= 5) begin
        vecs++;
        if (got_w !== exp_w) begin
          errs++;
          $display("FAIL odd_w%0d: got %h, want %h", i, got_w, exp_w);
        end
      end
    end
    vecs++;
    if (seq3 !== 16'd1) begin
      errs++;
      $display("FAIL odd_seq: got %0d, want 1", seq3);
    end
  endtask

  task automatic test_trigger_in_packet();
    logic [133:0] win [5];
    logic [136:0] wexp [5];
    win[0] = HEAD_IN; wexp[0] = {3'b100, HEAD_OUT};
    for (int i = 1; i < 4; i++) begin
      win[i]  = BODY_W ^ {6'h0, 122'h0, 6'(i)};
      wexp[i] = {3'b100, win[i]};
    end
    win[4] = TAIL_W; wexp[4] = {3'b111, TAIL_W};
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, win[i], i == 4);
      req8 = (i == 1);
      tick();
      vecs++;
      got_w = {wr8, v8, vwr8, d8};
      if (got_w !== wexp[i] || rdy8 !== 1'b1) begin
        errs++;
        $display("FAIL pkt_word%0d: got %h rdy=%b, want %h rdy=1", i, got_w, rdy8, wexp[i]);
      end
    end
    req8 = 1'b0;
    drive(1'b0, '0, 1'b0);
    tick();
    vecs++;
    if (rdy8 !== 1'b0 || wr8 !== 1'b0) begin
      errs++;
      $display("FAIL pkt_report_start: got rdy=%b wr=%b, want rdy=0 wr=0", rdy8, wr8);
    end
    for (int i = 0; i < 10; i++) begin
      tick();
      if (i == 0 || i == 4 || i == 9) begin
        case (i)
          0: exp_w = {3'b100, 2'b01, 4'h0, 32'h0, 8'd11, 88'h0};
          4: exp_w = {3'b100, 2'b11, 4'h0, 16'h0, 16'd1, T_IDLE, 48'h0};
          default: exp_w = {3'b111, 2'b10, 4'h0, 64'hffff_ffff_ffff_ffff, 64'hffff_ffff_ffff_ffff};
        endcase
        vecs++;
        got_w = {wr8, v8, vwr8, d8};
        if (got_w !== exp_w) begin
          errs++;
          $display("FAIL pkt_rpt_w%0d: got %h, want %h", i, got_w, exp_w);
        end
      end
    end
    vecs++;
    if (seq8 !== 16'd2) begin
      errs++;
      $display("FAIL pkt_seq: got %0d, want 2", seq8);
    end
  endtask

  task automatic test_coalesce();
    int words = 0;
    int tails = 0;
    for (int i = 0; i < 30; i++) begin
      req8 = (i < 3);
      tick();
      if (wr8 === 1'b1) words++;
      if (vwr8 === 1'b1) tails++;
    end
    vecs++;
    if (words != 10 || tails != 1) begin
      errs++;
      $display("FAIL coalesce_single: got words=%0d tails=%0d, want 10/1", words, tails);
    end
    vecs++;
    if (coal8 !== 16'd2 || seq8 !== 16'd3) begin
      errs++;
      $display("FAIL coalesce_cnt: got coal=%0d seq=%0d, want coal=2 seq=3", coal8, seq8);
    end
  endtask

  task automatic test_mid_reset();
    int words = 0;
    req8 = 1'b1;
    tick();
    req8 = 1'b0;
    for (int i = 0; i < 6; i++) tick();
    vecs++;
    got_w = {wr8, v8, vwr8, d8};
    exp_w = {3'b100, 2'b11, 4'h0, 16'h0, 16'd3, T_IDLE, 48'h0};
    if (got_w !== exp_w) begin
      errs++;
      $display("FAIL midrst_w4: got %h, want %h", got_w, exp_w);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    vecs++;
    got_w = {wr8, v8, vwr8, d8};
    if (got_w !== '0 || rdy8 !== 1'b0 || seq8 !== 16'h0) begin
      errs++;
      $display("FAIL midrst_outputs: got %h rdy=%b seq=%0d, want 0 rdy=0 seq=0", got_w, rdy8, seq8);
    end
    tick();
    vecs++;
    if (rdy8 !== 1'b1) begin
      errs++;
      $display("FAIL midrst_ready: got %b, want 1", rdy8);
    end
    for (int i = 0; i < 15; i++) begin
      tick();
      if (wr8 === 1'b1) words++;
    end
    vecs++;
    if (words != 0) begin
      errs++;
      $display("FAIL midrst_pending_lost: got %0d words, want 0", words);
    end
  endtask

  initial begin
    rst = 1'b1;
    drive(1'b0, '0, 1'b0);
    precision_time = T_IDLE;
    local_mac = 48'ha1a2a3a4a5a6;
    en8 = 1'b0; req8 = 1'b0; en3 = 1'b0; req3 = 1'b0;
    cnt8 = '0; cnt3 = '0;
    test_reset();
    test_pass();
    test_periodic();
    test_odd_count();
    test_trigger_in_packet();
    test_coalesce();
    test_mid_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
